// File: rtl/conn_rv_lookup_if.sv
// Connection-ID lookup channel between the Ethernet TX block (master) and the
// reverse-lookup engine (slave): request handshake plus buffered response handshake.
interface conn_rv_lookup_if #(
  parameter int CONN_ID_WIDTH = 6
);
  logic                     s_axis_rv_lookup_valid;
  logic [CONN_ID_WIDTH-1:0] s_axis_rv_lookup_connectionId;
  logic                     s_axis_rv_lookup_ready;
  logic                     m_axis_rv_lookup_valid;
  logic                     m_axis_rv_lookup_ready;
  logic                     m_axis_rv_lookup_hit;
  logic [47:0]              m_axis_rv_lookup_macAddr;
  logic [31:0]              m_axis_rv_lookup_ipAddr;
  logic [15:0]              m_axis_rv_lookup_udpPort;

  // Both channels transfer on the cycle where valid && ready is high; a valid
  // holder keeps its payload stable until that cycle and never waits on ready.
  modport slave (
    input  s_axis_rv_lookup_valid, s_axis_rv_lookup_connectionId, m_axis_rv_lookup_ready,
    output s_axis_rv_lookup_ready, m_axis_rv_lookup_valid, m_axis_rv_lookup_hit,
           m_axis_rv_lookup_macAddr, m_axis_rv_lookup_ipAddr, m_axis_rv_lookup_udpPort
  );

  modport master (
    output s_axis_rv_lookup_valid, s_axis_rv_lookup_connectionId, m_axis_rv_lookup_ready,
    input  s_axis_rv_lookup_ready, m_axis_rv_lookup_valid, m_axis_rv_lookup_hit,
           m_axis_rv_lookup_macAddr, m_axis_rv_lookup_ipAddr, m_axis_rv_lookup_udpPort
  );
endinterface

// File: rtl/conn_rv_lookup.sv
// Connection-table reverse-lookup engine: table read, fixed-latency pipeline, FWFT response FIFO.
// Optional RV_LOOKUP_STATS_EN adds saturating hit/miss counters on delivered responses.
module conn_rv_lookup #(
  parameter int NUM_CONNECTIONS = 64,
  parameter int CONN_ID_WIDTH   = $clog2(NUM_CONNECTIONS),
  parameter int LATENCY         = 3,
  parameter int RESP_DEPTH      = LATENCY + 2
) (
  input  logic                     tx_axis_aclk,
  input  logic                     tx_axis_areset,
  conn_rv_lookup_if.slave          lk,
  input  logic                     cfg_wr_en,
  input  logic [CONN_ID_WIDTH-1:0] cfg_wr_connectionId,
  input  logic                     cfg_wr_entryValid,
  input  logic [47:0]              cfg_wr_macAddr,
  input  logic [31:0]              cfg_wr_ipAddr,
  input  logic [15:0]              cfg_wr_udpPort,
  output logic [31:0]              stat_hit_count,
  output logic [31:0]              stat_miss_count
);
  typedef struct packed {
    logic        hit;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } resp_t;

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic                       clk, rst;
  logic [NUM_CONNECTIONS-1:0] tbl_valid;
  logic [47:0]                tbl_mac  [NUM_CONNECTIONS];
  logic [31:0]                tbl_ip   [NUM_CONNECTIONS];
  logic [15:0]                tbl_port [NUM_CONNECTIONS];
  logic                       accept, rd_in_range, wr_in_range;
  resp_t                      rd_resp, push_d, head;
  logic                       push_v, pop;
  logic [3:0]                 inflight;
  resp_t                      fifo_mem [RESP_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              fifo_count;

  assign clk = tx_axis_aclk;
  assign rst = tx_axis_areset;

  // Range checks only matter when NUM_CONNECTIONS is not a power of two.
  assign rd_in_range = ({{(32-CONN_ID_WIDTH){1'b0}}, lk.s_axis_rv_lookup_connectionId}
                        < 32'(NUM_CONNECTIONS));
  assign wr_in_range = ({{(32-CONN_ID_WIDTH){1'b0}}, cfg_wr_connectionId}
                        < 32'(NUM_CONNECTIONS));

  always_ff @(posedge clk) begin
    if (rst) tbl_valid <= '0;
    else if (cfg_wr_en && wr_in_range) tbl_valid[cfg_wr_connectionId] <= cfg_wr_entryValid;
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en && wr_in_range) begin
      tbl_mac[cfg_wr_connectionId]  <= cfg_wr_macAddr;
      tbl_ip[cfg_wr_connectionId]   <= cfg_wr_ipAddr;
      tbl_port[cfg_wr_connectionId] <= cfg_wr_udpPort;
    end
  end

  // Combinational read in the accept cycle: a same-cycle write lands at the
  // closing edge, so the lookup sees the pre-write entry.
  assign accept = lk.s_axis_rv_lookup_valid && lk.s_axis_rv_lookup_ready;

  always_comb begin
    rd_resp = '0;
    if (rd_in_range && tbl_valid[lk.s_axis_rv_lookup_connectionId]) begin
      rd_resp.hit  = 1'b1;
      rd_resp.mac  = tbl_mac[lk.s_axis_rv_lookup_connectionId];
      rd_resp.ip   = tbl_ip[lk.s_axis_rv_lookup_connectionId];
      rd_resp.port = tbl_port[lk.s_axis_rv_lookup_connectionId];
    end
  end

  // LATENCY-1 register stages; the FIFO write supplies the final cycle of latency.
  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] stg_v;
      resp_t              stg_d [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) stg_v <= '0;
        else begin
          stg_v[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) stg_v[i] <= stg_v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        stg_d[0] <= rd_resp;
        for (int i = 1; i < LATENCY - 1; i++) stg_d[i] <= stg_d[i-1];
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY - 1; i++) inflight = inflight + 4'(stg_v[i]);
      end

      assign push_v = stg_v[LATENCY-2];
      assign push_d = stg_d[LATENCY-2];
    end else begin : g_nopipe
      assign push_v   = accept;
      assign push_d   = rd_resp;
      assign inflight = '0;
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every accepted request holds a credit until popped, so the FIFO cannot overflow.
  assign lk.s_axis_rv_lookup_ready = !rst && ((int'(inflight) + int'(fifo_count)) < RESP_DEPTH);
  assign lk.m_axis_rv_lookup_valid = (fifo_count != '0);
  assign pop = lk.m_axis_rv_lookup_valid && lk.m_axis_rv_lookup_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      case ({push_v, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) fifo_mem[wr_ptr] <= push_d;
  end

  assign head = lk.m_axis_rv_lookup_valid ? fifo_mem[rd_ptr] : '0;
  assign lk.m_axis_rv_lookup_hit      = head.hit;
  assign lk.m_axis_rv_lookup_macAddr  = head.mac;
  assign lk.m_axis_rv_lookup_ipAddr   = head.ip;
  assign lk.m_axis_rv_lookup_udpPort  = head.port;

`ifdef RV_LOOKUP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_count  <= '0;
      stat_miss_count <= '0;
    end else if (pop) begin
      if (head.hit) begin
        if (stat_hit_count != 32'hFFFF_FFFF) stat_hit_count <= stat_hit_count + 32'd1;
      end else begin
        if (stat_miss_count != 32'hFFFF_FFFF) stat_miss_count <= stat_miss_count + 32'd1;
      end
    end
  end
`else
  assign stat_hit_count  = '0;
  assign stat_miss_count = '0;
`endif
endmodule

// File: tb/tb_conn_rv_lookup.sv
// Directed bench for conn_rv_lookup: drivers push expected responses on accept,
// a negedge monitor pops and compares every delivered response in order.
module tb_conn_rv_lookup;
  localparam int NUM = 64;
  localparam int IDW = 6;
  localparam int LAT = 3;
  localparam int DEPTH = 5;

  typedef logic [96:0] resp_bits_t;  // {hit, mac, ip, port}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conn_rv_lookup_if #(.CONN_ID_WIDTH(IDW)) bus();

  logic           cfg_wr_en = 1'b0;
  logic [IDW-1:0] cfg_wr_connectionId = '0;
  logic           cfg_wr_entryValid = 1'b0;
  logic [47:0]    cfg_wr_macAddr = '0;
  logic [31:0]    cfg_wr_ipAddr = '0;
  logic [15:0]    cfg_wr_udpPort = '0;
  logic [31:0]    stat_hit_count, stat_miss_count;

  conn_rv_lookup #(
    .NUM_CONNECTIONS(NUM), .CONN_ID_WIDTH(IDW), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .tx_axis_aclk(clk), .tx_axis_areset(rst), .lk(bus.slave),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_connectionId(cfg_wr_connectionId),
    .cfg_wr_entryValid(cfg_wr_entryValid), .cfg_wr_macAddr(cfg_wr_macAddr),
    .cfg_wr_ipAddr(cfg_wr_ipAddr), .cfg_wr_udpPort(cfg_wr_udpPort),
    .stat_hit_count(stat_hit_count), .stat_miss_count(stat_miss_count)
  );

  logic [96:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int accepts = 0;
  int resp_count = 0;
  int mdl_hit = 0;
  int mdl_miss = 0;
  int burst_mark = -1;
  int burst_first = 0;
  int burst_last = 0;

  localparam resp_bits_t E5 = {1'b1, 48'h02_00_00_00_00_05, 32'h0A00_0005, 16'd4791};
  localparam resp_bits_t N3 = {1'b1, 48'hAA_BB_CC_DD_EE_FF, 32'hC0A8_0003, 16'd1234};
  localparam resp_bits_t MISS = '0;

  function automatic resp_bits_t ent(input int id);
    return {1'b1, 48'h02_00_00_00_00_00 | 48'(id), 32'h0A00_0000 | 32'(id), 16'(4000 + id)};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (!rst && bus.s_axis_rv_lookup_valid && bus.s_axis_rv_lookup_ready) accepts++;

  // Response monitor / scoreboard
  always @(negedge clk) begin
    resp_bits_t got, e;
    if (!rst && bus.m_axis_rv_lookup_valid && bus.m_axis_rv_lookup_ready) begin
      got = {bus.m_axis_rv_lookup_hit, bus.m_axis_rv_lookup_macAddr,
             bus.m_axis_rv_lookup_ipAddr, bus.m_axis_rv_lookup_udpPort};
      if (resp_count == burst_mark) burst_first = cyc;
      burst_last = cyc;
      resp_count++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL resp_unexpected: got %h, required no response", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          mismatched++;
          $display("FAIL resp_data: got %h, required %h", got, e);
        end
        if (e[96]) mdl_hit++;
        else mdl_miss++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int id, input resp_bits_t e, input logic v);
    cfg_wr_en = 1'b1;
    cfg_wr_connectionId = IDW'(id);
    cfg_wr_entryValid = v;
    {cfg_wr_macAddr, cfg_wr_ipAddr, cfg_wr_udpPort} = e[95:0];
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // Presents one request; pushes the expectation when it will be accepted at the next edge.
  task automatic lookup(input int id, input resp_bits_t e);
    bus.s_axis_rv_lookup_valid = 1'b1;
    bus.s_axis_rv_lookup_connectionId = IDW'(id);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.s_axis_rv_lookup_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        return;
      end
    end
    check("lookup_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.s_axis_rv_lookup_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input string name);
    @(negedge clk);
`ifdef RV_LOOKUP_STATS_EN
    check({name, "_hit"}, 64'(stat_hit_count), 64'(mdl_hit));
    check({name, "_miss"}, 64'(stat_miss_count), 64'(mdl_miss));
`else
    check({name, "_hit"}, 64'(stat_hit_count), 64'd0);
    check({name, "_miss"}, 64'(stat_miss_count), 64'd0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rbase, abase, start;
    bus.s_axis_rv_lookup_valid = 1'b0;
    bus.s_axis_rv_lookup_connectionId = '0;
    bus.m_axis_rv_lookup_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 64'(bus.s_axis_rv_lookup_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 64'(bus.s_axis_rv_lookup_ready), 64'd1);
    check("rst_m_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd0);
    check("rst_hit", 64'(bus.m_axis_rv_lookup_hit), 64'd0);
    check("rst_mac", 64'(bus.m_axis_rv_lookup_macAddr), 64'd0);
    check("rst_ip", 64'(bus.m_axis_rv_lookup_ipAddr), 64'd0);
    check("rst_port", 64'(bus.m_axis_rv_lookup_udpPort), 64'd0);
    check("rst_stat_hit", 64'(stat_hit_count), 64'd0);
    check("rst_stat_miss", 64'(stat_miss_count), 64'd0);
    @(posedge clk); #1;

    // Basic hit with latency check
    cfg_write(5, E5, 1'b1);
    lookup(5, E5);
    idle();
    @(negedge clk);
    check("lat_t1_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check("lat_t2_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check("lat_t3_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd1);
    check("lat_t3_hit", 64'(bus.m_axis_rv_lookup_hit), 64'd1);
    @(posedge clk); #1;
    wait_drain("drain_hit");

    // Misses: never-written ID and deleted entry
    lookup(7, MISS);
    idle();
    cfg_write(5, E5, 1'b0);
    lookup(5, MISS);
    idle();
    wait_drain("drain_miss");
    check_stats("stats_after_miss");

    // Backpressure: only DEPTH requests fit while m_ready is low
    for (int i = 0; i < 10; i++) cfg_write(i, ent(i), 1'b1);
    bus.m_axis_rv_lookup_ready = 1'b0;
    abase = accepts;
    rbase = resp_count;
    fork
      begin
        for (int i = 0; i < 10; i++) lookup(i, ent(i));
        idle();
      end
      begin
        repeat (15) @(negedge clk);
        check("bp_accepts", 64'(accepts - abase), 64'd5);
        check("bp_s_ready", 64'(bus.s_axis_rv_lookup_ready), 64'd0);
        check("bp_m_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd1);
        check("bp_head_mac", 64'(bus.m_axis_rv_lookup_macAddr), 64'(ent(0)[95:48]));
        @(posedge clk); #1;
        bus.m_axis_rv_lookup_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_pop", 64'(bus.s_axis_rv_lookup_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        check("bp_ready_after_pop", 64'(bus.s_axis_rv_lookup_ready), 64'd1);
      end
    join
    wait_drain("drain_bp");
    check("bp_resp_total", 64'(resp_count - rbase), 64'd10);

    // Same-cycle write and lookup of ID 3
    cfg_wr_en = 1'b1;
    cfg_wr_connectionId = IDW'(3);
    cfg_wr_entryValid = 1'b1;
    {cfg_wr_macAddr, cfg_wr_ipAddr, cfg_wr_udpPort} = N3[95:0];
    lookup(3, ent(3));
    cfg_wr_en = 1'b0;
    lookup(3, N3);
    idle();
    wait_drain("drain_same_cycle");

    // Reset with lookups in flight
    bus.m_axis_rv_lookup_ready = 1'b0;
    lookup(1, ent(1));
    lookup(2, ent(2));
    lookup(3, N3);
    idle();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_hit = 0;
    mdl_miss = 0;
    bus.m_axis_rv_lookup_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(bus.m_axis_rv_lookup_valid), 64'd0);
    end
    check("midrst_s_ready", 64'(bus.s_axis_rv_lookup_ready), 64'd1);
    @(posedge clk); #1;
    check_stats("stats_after_reset");
    for (int i = 0; i < NUM; i++) lookup(i, MISS);
    idle();
    wait_drain("drain_all_miss");
    check_stats("stats_all_miss");

    // Sustained back-to-back throughput
    for (int i = 0; i < 10; i++) cfg_write(i, ent(i), 1'b1);
    burst_mark = resp_count;
    rbase = resp_count;
    start = cyc;
    for (int i = 0; i < 1000; i++) lookup(i % NUM, ((i % NUM) < 10) ? ent(i % NUM) : MISS);
    idle();
    check("burst_accept_cycles", 64'(cyc - start), 64'd1000);
    wait_drain("drain_burst");
    check("burst_resp_total", 64'(resp_count - rbase), 64'd1000);
    check("burst_resp_span", 64'(burst_last - burst_first), 64'd999);
    check_stats("stats_burst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
